// File: rtl/ysyx_22041461_wb_commit.sv
// Writeback/commit stage: retires MEM/WB bundles and owns the machine-mode CSRs.
// Latency: GPR write port is combinational; CSR/counter updates land on the same edge; redirect appears one cycle later.
// Backpressure: none; every valid bundle is consumed in its cycle, and a halted core silently drops input.
//
// Optional counters: define YSYX_22041461_ZICNTR_EN to build mcycle/minstret
// (CSR 0xB00/0xB02, minstret_out). Undefined: both read 0, writes ignored, minstret_out=0.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   wb_valid            bundle valid (0 = bubble)
//   wb_EXE/MEM/imm/zimm candidate writeback values / CSR sources
//   wb_rd, wb_csr       GPR index, CSR address
//   wb_pc               instruction PC
//   wb_ctrl             writeback op code
//   rf_wen/waddr/wdata  GPR write port
//   redirect_valid/pc   one-cycle fetch redirect
//   halt                sticky ebreak flag
//   minstret_out        retired instruction count
module ysyx_22041461_wb_commit #(
  parameter int unsigned           XLEN        = 64,
  parameter logic [XLEN-1:0]       MSTATUS_RST = 64'h0000000A00001800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_EXE,
  input  logic [XLEN-1:0] wb_MEM,
  input  logic [4:0]      wb_rd,
  input  logic [11:0]     wb_csr,
  input  logic [XLEN-1:0] wb_imm,
  input  logic [XLEN-1:0] wb_zimm,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [3:0]      wb_ctrl,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            halt,
  output logic [XLEN-1:0] minstret_out
);

  localparam logic [3:0] CTRL_NOP    = 4'd0;
  localparam logic [3:0] CTRL_EXE    = 4'd1;
  localparam logic [3:0] CTRL_MEM    = 4'd2;
  localparam logic [3:0] CTRL_IMM    = 4'd3;
  localparam logic [3:0] CTRL_LINK   = 4'd4;
  localparam logic [3:0] CTRL_CSRRW  = 4'd5;
  localparam logic [3:0] CTRL_CSRRS  = 4'd6;
  localparam logic [3:0] CTRL_CSRRC  = 4'd7;
  localparam logic [3:0] CTRL_CSRRWI = 4'd8;
  localparam logic [3:0] CTRL_CSRRSI = 4'd9;
  localparam logic [3:0] CTRL_CSRRCI = 4'd10;
  localparam logic [3:0] CTRL_ECALL  = 4'd11;
  localparam logic [3:0] CTRL_MRET   = 4'd12;
  localparam logic [3:0] CTRL_EBREAK = 4'd13;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  // mstatus bit positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;

  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_halt;

  logic            w_active;
  logic            w_is_csr;
  logic            w_is_rw;
  logic            w_is_rs;
  logic            w_is_rc;
  logic [XLEN-1:0] w_csr_src;
  logic [XLEN-1:0] w_csr_old;
  logic [XLEN-1:0] w_csr_new;
  logic            w_csr_we;
  logic            w_gpr_op;
  logic            w_retire;

  // A halted core behaves as if every bundle were a bubble.
  assign w_active = wb_valid && !r_halt;

  assign w_is_rw  = (wb_ctrl == CTRL_CSRRW) || (wb_ctrl == CTRL_CSRRWI);
  assign w_is_rs  = (wb_ctrl == CTRL_CSRRS) || (wb_ctrl == CTRL_CSRRSI);
  assign w_is_rc  = (wb_ctrl == CTRL_CSRRC) || (wb_ctrl == CTRL_CSRRCI);
  assign w_is_csr = w_is_rw || w_is_rs || w_is_rc;
  assign w_csr_src = (wb_ctrl >= CTRL_CSRRWI) ? wb_zimm : wb_EXE;

  assign w_gpr_op = (wb_ctrl >= CTRL_EXE) && (wb_ctrl <= CTRL_CSRRCI);
  // Codes 14/15 are NOPs and do not retire.
  assign w_retire = w_active && (wb_ctrl != CTRL_NOP) && (wb_ctrl <= CTRL_EBREAK);

`ifdef YSYX_22041461_ZICNTR_EN
  logic [XLEN-1:0] r_mcycle;
  logic [XLEN-1:0] r_minstret;
`endif

  // CSR read mux (value before this cycle's update)
  always_comb begin
    w_csr_old = '0;
    case (wb_csr)
      CSR_MSTATUS:  w_csr_old = r_mstatus;
      CSR_MTVEC:    w_csr_old = r_mtvec;
      CSR_MEPC:     w_csr_old = r_mepc;
      CSR_MCAUSE:   w_csr_old = r_mcause;
`ifdef YSYX_22041461_ZICNTR_EN
      CSR_MCYCLE:   w_csr_old = r_mcycle;
      CSR_MINSTRET: w_csr_old = r_minstret;
`endif
      default:      w_csr_old = '0;
    endcase
  end

  always_comb begin
    w_csr_new = w_csr_src;
    if (w_is_rs) w_csr_new = w_csr_old | w_csr_src;
    if (w_is_rc) w_csr_new = w_csr_old & ~w_csr_src;
  end

  // Set/clear with a zero source is a pure read.
  assign w_csr_we = w_active && w_is_csr && (w_is_rw || (w_csr_src != '0));

  // GPR write port
  always_comb begin
    rf_wdata = '0;
    case (wb_ctrl)
      CTRL_EXE:  rf_wdata = wb_EXE;
      CTRL_MEM:  rf_wdata = wb_MEM;
      CTRL_IMM:  rf_wdata = wb_imm;
      CTRL_LINK: rf_wdata = wb_pc + XLEN'(4);
      default:   rf_wdata = w_is_csr ? w_csr_old : '0;
    endcase
  end

  assign rf_wen   = rst && w_active && w_gpr_op && (wb_rd != 5'd0);
  assign rf_waddr = wb_rd;

  // Architectural CSRs, trap handling, redirect and halt
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mstatus        <= MSTATUS_RST;
      r_mtvec          <= '0;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_halt           <= 1'b0;
    end else begin
      r_redirect_valid <= 1'b0;
      if (w_csr_we) begin
        case (wb_csr)
          CSR_MSTATUS: r_mstatus <= w_csr_new;
          CSR_MTVEC:   r_mtvec   <= w_csr_new;
          CSR_MEPC:    r_mepc    <= w_csr_new;
          CSR_MCAUSE:  r_mcause  <= w_csr_new;
          default: ;
        endcase
      end
      if (w_active) begin
        case (wb_ctrl)
          CTRL_ECALL: begin
            r_mepc                     <= wb_pc;
            r_mcause                   <= XLEN'(11);
            r_mstatus[MPIE_BIT]        <= r_mstatus[MIE_BIT];
            r_mstatus[MIE_BIT]         <= 1'b0;
            r_mstatus[MPP_LO+1:MPP_LO] <= 2'b11;
            r_redirect_valid           <= 1'b1;
            r_redirect_pc              <= r_mtvec;
          end
          CTRL_MRET: begin
            r_mstatus[MIE_BIT]         <= r_mstatus[MPIE_BIT];
            r_mstatus[MPIE_BIT]        <= 1'b1;
            r_mstatus[MPP_LO+1:MPP_LO] <= 2'b00;
            r_redirect_valid           <= 1'b1;
            r_redirect_pc              <= r_mepc;
          end
          CTRL_EBREAK: r_halt <= 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef YSYX_22041461_ZICNTR_EN
  // A CSR write to a counter takes priority over its own increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_csr_we && (wb_csr == CSR_MCYCLE)) r_mcycle <= w_csr_new;
      else                                    r_mcycle <= r_mcycle + XLEN'(1);

      if (w_csr_we && (wb_csr == CSR_MINSTRET)) r_minstret <= w_csr_new;
      else if (w_retire)                        r_minstret <= r_minstret + XLEN'(1);
    end
  end

  assign minstret_out = r_minstret;
`else
  assign minstret_out = '0;
`endif

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign halt           = r_halt;

endmodule

// File: tb/tb_ysyx_22041461_wb_commit.sv
// Directed bench for the writeback/commit stage.
// Inputs change 1 time unit after posedge; outputs are sampled there or 1 unit later.
// Expected values are hand-computed constants.
module tb_ysyx_22041461_wb_commit;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [63:0] wb_EXE;
  logic [63:0] wb_MEM;
  logic [4:0]  wb_rd;
  logic [11:0] wb_csr;
  logic [63:0] wb_imm;
  logic [63:0] wb_zimm;
  logic [63:0] wb_pc;
  logic [3:0]  wb_ctrl;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic [63:0] minstret_out;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] MSTATUS_RST = 64'h0000000A00001800;

  ysyx_22041461_wb_commit dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_EXE(wb_EXE), .wb_MEM(wb_MEM),
    .wb_rd(wb_rd), .wb_csr(wb_csr), .wb_imm(wb_imm), .wb_zimm(wb_zimm), .wb_pc(wb_pc),
    .wb_ctrl(wb_ctrl), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .minstret_out(minstret_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [3:0] ctrl, input logic [4:0] rd,
                        input logic [63:0] exe, input logic [11:0] csr,
                        input logic [63:0] zimm, input logic [63:0] pc);
    wb_valid = v;
    wb_ctrl  = ctrl;
    wb_rd    = rd;
    wb_EXE   = exe;
    wb_csr   = csr;
    wb_zimm  = zimm;
    wb_pc    = pc;
  endtask

  task automatic bubble();
    set_op(1'b0, 4'd0, 5'd0, 64'd0, 12'd0, 64'd0, 64'd0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_op(1'b1, 4'd1, 5'd5, 64'h55, 12'd0, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got %0b want 0", rf_wen); end
    tick(); tick();
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 64'd0 || halt !== 1'b0 || minstret_out !== 64'd0) begin
      errors++;
      $display("FAIL reset_state got rv=%0b rpc=%h halt=%0b minstret=%0d want 0/0/0/0",
               redirect_valid, redirect_pc, halt, minstret_out);
    end
    rst = 1'b1;
    // Read mstatus with CSRRS src=0
    set_op(1'b1, 4'd6, 5'd1, 64'd0, 12'h300, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== MSTATUS_RST) begin errors++; $display("FAIL reset_mstatus got %h want %h", rf_wdata, MSTATUS_RST); end
    tick();
    bubble();
  endtask

  task automatic test_gpr();
    set_op(1'b1, 4'd1, 5'd5, 64'h1234, 12'd0, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234) begin
      errors++; $display("FAIL gpr_exe got wen=%0b addr=%0d data=%h want 1/5/1234", rf_wen, rf_waddr, rf_wdata);
    end
    wb_rd = 5'd0;
    #1;
    checks++;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL gpr_rd0 got wen=%0b want 0", rf_wen); end
    tick();
    wb_ctrl = 4'd2; wb_rd = 5'd7; wb_MEM = 64'hFFFF_FFFF_FFFF_FF80;
    #1;
    checks++;
    if (rf_wen !== 1'b1 || rf_wdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
      errors++; $display("FAIL gpr_mem got wen=%0b data=%h want 1/ffffffffffffff80", rf_wen, rf_wdata);
    end
    wb_ctrl = 4'd3; wb_imm = 64'h0000_0000_0001_2000;
    #1;
    checks++;
    if (rf_wdata !== 64'h12000) begin errors++; $display("FAIL gpr_imm got %h want 12000", rf_wdata); end
    wb_ctrl = 4'd4; wb_pc = 64'h8000_0010;
    #1;
    checks++;
    if (rf_wdata !== 64'h8000_0014) begin errors++; $display("FAIL gpr_link got %h want 80000014", rf_wdata); end
    wb_ctrl = 4'd14;
    #1;
    checks++;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL gpr_undef_code got wen=%0b want 0", rf_wen); end
    wb_ctrl = 4'd1; wb_valid = 1'b0;
    #1;
    checks++;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL gpr_bubble got wen=%0b want 0", rf_wen); end
    tick();
    bubble();
  endtask

  task automatic test_csr();
    // CSRRW mtvec
    set_op(1'b1, 4'd5, 5'd3, 64'h8000_0100, 12'h305, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wen !== 1'b1 || rf_wdata !== 64'd0) begin
      errors++; $display("FAIL csrrw_old got wen=%0b data=%h want 1/0", rf_wen, rf_wdata);
    end
    tick();
    // CSRRS src=0: read, no write
    set_op(1'b1, 4'd6, 5'd1, 64'd0, 12'h305, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== 64'h8000_0100) begin errors++; $display("FAIL csrrw_new got %h want 80000100", rf_wdata); end
    tick();
    #1;
    checks++;
    if (rf_wdata !== 64'h8000_0100) begin errors++; $display("FAIL csrrs_zero got %h want 80000100", rf_wdata); end
    // mcause: set bits 0..1, then clear bit 0
    set_op(1'b1, 4'd9, 5'd2, 64'd0, 12'h342, 64'd3, 64'd0);
    tick();
    set_op(1'b1, 4'd10, 5'd2, 64'd0, 12'h342, 64'd1, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== 64'd3) begin errors++; $display("FAIL csrrsi got %h want 3", rf_wdata); end
    tick();
    set_op(1'b1, 4'd7, 5'd2, 64'd0, 12'h342, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== 64'd2) begin errors++; $display("FAIL csrrci got %h want 2", rf_wdata); end
    tick();
    // Unmapped CSR: write ignored, reads 0
    set_op(1'b1, 4'd5, 5'd4, 64'hDEAD_BEEF, 12'h7C0, 64'd0, 64'd0);
    tick();
    set_op(1'b1, 4'd6, 5'd4, 64'd0, 12'h7C0, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== 64'd0) begin errors++; $display("FAIL csr_unmapped got %h want 0", rf_wdata); end
    // Counters read 0 when not built
    wb_csr = 12'hB02;
    #1;
`ifndef YSYX_22041461_ZICNTR_EN
    checks++;
    if (rf_wdata !== 64'd0) begin errors++; $display("FAIL csr_minstret_absent got %h want 0", rf_wdata); end
`endif
    tick();
    bubble();
  endtask

  task automatic test_ecall();
    // Set MIE so the MPIE copy is observable
    set_op(1'b1, 4'd9, 5'd1, 64'd0, 12'h300, 64'd8, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== MSTATUS_RST) begin errors++; $display("FAIL mstatus_pre got %h want %h", rf_wdata, MSTATUS_RST); end
    tick();
    set_op(1'b1, 4'd11, 5'd0, 64'd0, 12'd0, 64'd0, 64'h8000_0040);
    tick();
    bubble();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100) begin
      errors++; $display("FAIL ecall_redirect got v=%0b pc=%h want 1/80000100", redirect_valid, redirect_pc);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $display("FAIL ecall_pulse_len got v=%0b want 0", redirect_valid); end
    set_op(1'b1, 4'd6, 5'd1, 64'd0, 12'h341, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== 64'h8000_0040) begin errors++; $display("FAIL ecall_mepc got %h want 80000040", rf_wdata); end
    wb_csr = 12'h342;
    #1;
    checks++;
    if (rf_wdata !== 64'd11) begin errors++; $display("FAIL ecall_mcause got %h want b", rf_wdata); end
    wb_csr = 12'h300;
    #1;
    checks++;
    if (rf_wdata !== 64'h0000000A00001880) begin errors++; $display("FAIL ecall_mstatus got %h want a00001880", rf_wdata); end
    tick();
    bubble();
  endtask

  task automatic test_mret();
    set_op(1'b1, 4'd5, 5'd0, 64'h8000_0044, 12'h341, 64'd0, 64'd0);
    tick();
    set_op(1'b1, 4'd12, 5'd0, 64'd0, 12'd0, 64'd0, 64'h8000_0100);
    tick();
    bubble();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0044) begin
      errors++; $display("FAIL mret_redirect got v=%0b pc=%h want 1/80000044", redirect_valid, redirect_pc);
    end
    set_op(1'b1, 4'd6, 5'd1, 64'd0, 12'h300, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== 64'h0000000A00000088) begin errors++; $display("FAIL mret_mstatus got %h want a00000088", rf_wdata); end
    tick();
    bubble();
  endtask

  task automatic test_back_to_back();
    set_op(1'b1, 4'd11, 5'd0, 64'd0, 12'd0, 64'd0, 64'h8000_0200);
    tick();
    set_op(1'b1, 4'd12, 5'd0, 64'd0, 12'd0, 64'd0, 64'h8000_0100);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100) begin
      errors++; $display("FAIL b2b_first got v=%0b pc=%h want 1/80000100", redirect_valid, redirect_pc);
    end
    tick();
    bubble();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0200) begin
      errors++; $display("FAIL b2b_second got v=%0b pc=%h want 1/80000200", redirect_valid, redirect_pc);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got v=%0b want 0", redirect_valid); end
  endtask

  task automatic test_reset_mid_trap();
    set_op(1'b1, 4'd11, 5'd0, 64'd0, 12'd0, 64'd0, 64'h8000_0300);
    rst = 1'b0;
    tick();
    bubble();
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 64'd0) begin
      errors++; $display("FAIL rst_trap_redirect got v=%0b pc=%h want 0/0", redirect_valid, redirect_pc);
    end
    rst = 1'b1;
    tick();
    set_op(1'b1, 4'd6, 5'd1, 64'd0, 12'h305, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== 64'd0) begin errors++; $display("FAIL rst_trap_mtvec got %h want 0", rf_wdata); end
    wb_csr = 12'h341;
    #1;
    checks++;
    if (rf_wdata !== 64'd0) begin errors++; $display("FAIL rst_trap_mepc got %h want 0", rf_wdata); end
    wb_csr = 12'h342;
    #1;
    checks++;
    if (rf_wdata !== 64'd0) begin errors++; $display("FAIL rst_trap_mcause got %h want 0", rf_wdata); end
    wb_csr = 12'h300;
    #1;
    checks++;
    if (rf_wdata !== MSTATUS_RST) begin errors++; $display("FAIL rst_trap_mstatus got %h want %h", rf_wdata, MSTATUS_RST); end
    tick();
    bubble();
  endtask

  task automatic test_ebreak();
    logic [63:0] exp_ret;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_op(1'b1, 4'd4, 5'd1, 64'd0, 12'd0, 64'd0, 64'h8000_0000);
    tick();
    wb_ctrl = 4'd3;
    tick();
    wb_ctrl = 4'd13;
    tick();
    checks++;
    if (halt !== 1'b1) begin errors++; $display("FAIL ebreak_halt got %0b want 1", halt); end
`ifdef YSYX_22041461_ZICNTR_EN
    exp_ret = 64'd3;
`else
    exp_ret = 64'd0;
`endif
    checks++;
    if (minstret_out !== exp_ret) begin errors++; $display("FAIL ebreak_minstret got %0d want %0d", minstret_out, exp_ret); end
    set_op(1'b1, 4'd1, 5'd5, 64'h1234, 12'd0, 64'd0, 64'd0);
    #1;
    checks++;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL halt_rf_wen got %0b want 0", rf_wen); end
    tick();
    set_op(1'b1, 4'd11, 5'd0, 64'd0, 12'd0, 64'd0, 64'h8000_0050);
    tick();
    bubble();
    checks++;
    if (redirect_valid !== 1'b0 || halt !== 1'b1 || minstret_out !== exp_ret) begin
      errors++; $display("FAIL halt_ignore got v=%0b halt=%0b minstret=%0d want 0/1/%0d",
                         redirect_valid, halt, minstret_out, exp_ret);
    end
  endtask

  initial begin
    rst = 1'b0;
    wb_MEM = 64'd0;
    wb_imm = 64'd0;
    bubble();
    test_reset();
    test_gpr();
    test_csr();
    test_ecall();
    test_mret();
    test_back_to_back();
    test_reset_mid_trap();
    test_ebreak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22041461_wb_commit.md
Name: ysyx_22041461_WB_commit

Overview:
- Writeback/commit stage. Consumes the registered MEM/WB pipeline bundle and retires each valid instruction.
- Per retired instruction it:
  - drives the GPR write port,
  - executes CSR read-modify-write,
  - handles ecall/mret/ebreak,
  - issues a registered one-cycle PC redirect to the fetch stage.
- Owns the machine-mode CSR state (mstatus, mtvec, mepc, mcause) and the retire counter.

Parameters:
- XLEN, 64, datapath width.
- MSTATUS_RST, 64'h0000000A00001800, mstatus reset value.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- wb_valid  in  1  bundle valid; 0 means bubble, no architectural effect.
- wb_EXE  in  64  ALU result. For CSR register-source ops it carries the rs1 operand value.
- wb_MEM  in  64  load data, already extended.
- wb_rd  in  5  destination register index.
- wb_csr  in  12  CSR address.
- wb_imm  in  64  immediate.
- wb_zimm  in  64  zero-extended CSR immediate.
- wb_pc  in  64  instruction PC.
- wb_ctrl  in  4  writeback op (encoding below).
- rf_wen  out  1  GPR write enable.
- rf_waddr  out  5  GPR write index.
- rf_wdata  out  64  GPR write data.
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  64  redirect target.
- halt  out  1  sticky, set by ebreak.
- minstret_out  out  64  retired-instruction count.

Behaviour:
- wb_ctrl encoding; undefined codes 14–15 behave as NOP:
  - 0 NOP
  - 1 EXE: rd <= wb_EXE
  - 2 MEM: rd <= wb_MEM
  - 3 IMM: rd <= wb_imm
  - 4 LINK: rd <= wb_pc+4
  - 5 CSRRW, 6 CSRRS, 7 CSRRC: source = wb_EXE
  - 8 CSRRWI, 9 CSRRSI, 10 CSRRCI: source = wb_zimm
  - 11 ECALL
  - 12 MRET
  - 13 EBREAK
- GPR write port is combinational from the inputs (regfile samples on the same edge):
  - rf_wen = wb_valid && (ctrl in 1..10) && wb_rd != 0 && !halt.
  - rf_waddr = wb_rd. rf_wdata = selected value.
  - For CSR ops, rf_wdata = old CSR value before this cycle's update.
- CSR read-modify-write:
  - new value = src for RW, old|src for RS, old&~src for RC.
  - RS/RC with src==0 performs no write. RW always writes.
  - Update is committed at the same clock edge.
- CSR map:
  - 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause: full 64-bit read/write.
  - 0xB00 mcycle, 0xB02 minstret: see Optional Feature.
  - Any other address: reads 0, writes ignored, no exception.
- ECALL (valid):
  - mepc <= wb_pc; mcause <= 11.
  - mstatus.MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
  - Next cycle: redirect_valid=1, redirect_pc = mtvec as of the ECALL cycle.
- MRET (valid):
  - mstatus.MIE <= MPIE, MPIE <= 1, MPP <= 2'b00.
  - Next cycle: redirect_valid=1, redirect_pc = mepc as of the MRET cycle.
- redirect_valid is high exactly one cycle per ECALL/MRET. Back-to-back traps give back-to-back pulses.
- A CSR write to mtvec/mepc in cycle N is visible to an ECALL/MRET in cycle N+1.
- EBREAK (valid): halt <= 1, sticky until reset. While halt=1, all inputs are ignored: no GPR/CSR/counter effects, no redirect.
- minstret:
  - +1 on every cycle with wb_valid && ctrl != NOP && !halt; the EBREAK itself counts.
  - Wraps modulo 2^64.
  - A CSR write to minstret in the same cycle wins over the increment.
- wb_valid=0: no state change except mcycle; redirect_valid <= 0.
- Reset (rst==0 at posedge, including mid-trap):
  - mstatus=MSTATUS_RST; mtvec=mepc=mcause=0.
  - counters 0, redirect_valid=0, redirect_pc=0, halt=0.
  - A pending redirect is dropped.
  - rf_wen is forced 0 while rst==0.

Optional Feature:
- Macro: YSYX_22041461_ZICNTR_EN.
- Defined:
  - mcycle increments every non-reset cycle, including during halt.
  - mcycle (0xB00) and minstret (0xB02) are CSR readable and writable.
  - minstret_out drives the counter.
- Undefined:
  - No counter registers exist.
  - 0xB00/0xB02 read 0, writes ignored.
  - minstret_out tied 0.

Test Plan:
- Reset, then valid EXE op with rd=5, EXE=0x1234 -> rf_wen=1, waddr=5, wdata=0x1234. Same op with rd=0 -> rf_wen=0.
- CSRRW 0x305 with EXE=0x80000100, rd=3 -> wdata=0 (old mtvec); next cycle mtvec reads 0x80000100. CSRRS 0x305 with src=0 -> mtvec unchanged.
- mtvec=0x80000100, ECALL at pc=0x80000040 -> next cycle redirect_valid=1, redirect_pc=0x80000100, for exactly one cycle; mepc=0x80000040, mcause=11, MIE=0, MPIE=old MIE.
- CSRRW mepc=0x80000044 then MRET in the following cycle -> redirect_pc=0x80000044; MIE restored from MPIE.
- ECALL, then rst=0 on the following edge -> redirect_valid stays 0; all CSRs return to reset values.
- EBREAK -> halt=1. A subsequent valid EXE op gives rf_wen=0. With ZICNTR_EN, minstret counts 3 for LINK, IMM, EBREAK.
